// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the load/store unit. It accepts one request at a
// time, holds it for WAIT_STATES cycles, then performs the RAM access and
// answers with a one-cycle ack carrying the full aligned word.
//
// Parameters:
//   DEPTH_WORDS  RAM depth in 32-bit words (power of two, >= 4)
//   WAIT_STATES  extra cycles between acceptance and response (0..15)
//   BASE_ADDR    byte address of word 0 (aligned to 4*DEPTH_WORDS)
//
// Ports:
//   clk            sole clock, rising edge
//   reset          synchronous, active-high reset
//   read_address   byte address of the load
//   read           load request
//   write_address  byte address of the store
//   write_data     store data, replicated across lanes by the requester
//   we_mem         byte-lane write enable (bit n -> lane n)
//   busy           request in flight; new requests ignored while high
//   ack            one-cycle response strobe
//   read_data      aligned word at read_address, held until the next ack
//   error          access fault, valid only with ack
//
// Configuration:
//   DMEM_RANGE_CHECK_EN  when defined, accesses outside
//                        [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS) fault with
//                        error=1, perform no write and return 0. When
//                        undefined, error is 0 and addresses alias modulo
//                        the RAM size.
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] read_address,
    input  logic        read,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic [3:0]  we_mem,
    output logic        busy,
    output logic        ack,
    output logic [31:0] read_data,
    output logic        error
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;

    // Request captured at acceptance; the RAM access uses these, not the
    // live inputs, so requester changes after acceptance have no effect.
    logic            rd_q;
    logic [3:0]      we_q;
    logic [AW-1:0]   rd_idx_q, wr_idx_q;
    logic [31:0]     wdata_q;
    logic            err_q;

    logic [31:0]     read_data_q;
    logic            error_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            req;
    logic            req_err;
    logic            accept;
    logic            enter_resp;

    // Effective access: live inputs when RESP is entered straight from IDLE
    // (WAIT_STATES == 0), otherwise the captured request.
    logic            a_rd;
    logic [3:0]      a_we;
    logic [AW-1:0]   a_rd_idx, a_wr_idx;
    logic [31:0]     a_wdata;
    logic            a_err;

    // Only the word-index bits of the addresses reach the RAM.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^{read_address, write_address};

    assign req    = read | (|we_mem);
    assign accept = (state_q == IDLE) && req;

`ifdef DMEM_RANGE_CHECK_EN
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] offset;
        offset = addr - BASE_ADDR;
        // Addresses below BASE_ADDR wrap to large offsets and fail too.
        return {1'b0, offset} < SPAN;
    endfunction

    assign req_err = (read && !in_range(read_address)) ||
                     ((|we_mem) && !in_range(write_address));
`else
    assign req_err = 1'b0;
`endif

    // NOTE: every variable assigned in an always_comb gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    always_comb begin
        a_rd     = rd_q;
        a_we     = we_q;
        a_rd_idx = rd_idx_q;
        a_wr_idx = wr_idx_q;
        a_wdata  = wdata_q;
        a_err    = err_q;
        if (state_q == IDLE) begin
            a_rd     = read;
            a_we     = we_mem;
            a_rd_idx = read_address[AW+1:2];
            a_wr_idx = write_address[AW+1:2];
            a_wdata  = write_data;
            a_err    = req_err;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; this is also what makes the RAM read return
    // the pre-write word when read and write alias.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            read_data_q <= 32'd0;
            error_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (enter_resp) begin
                error_q <= a_err;
                if (a_err)     read_data_q <= 32'd0;
                else if (a_rd) read_data_q <= mem[a_rd_idx];
            end else if (state_q == RESP) begin
                error_q <= 1'b0;
            end
        end
    end

    // Captured request is only consumed after acceptance, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            rd_q     <= read;
            we_q     <= we_mem;
            rd_idx_q <= read_address[AW+1:2];
            wr_idx_q <= write_address[AW+1:2];
            wdata_q  <= write_data;
            err_q    <= req_err;
        end
    end

    // NOTE: the RAM array is deliberately not reset; its contents survive
    // reset, and a reset on the write edge suppresses the pending store.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && !a_err) begin
            for (int n = 0; n < 4; n++) begin
                if (a_we[n]) mem[a_wr_idx][8*n +: 8] <= a_wdata[8*n +: 8];
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign ack       = (state_q == RESP);
    assign read_data = read_data_q;
    assign error     = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Directed bench for dmem_responder. Two instances share clock and reset:
// u_dut1 with WAIT_STATES=1 and u_dut0 with WAIT_STATES=0. Expected values
// are hand-computed constants. DMEM_RANGE_CHECK_EN selects the expected
// outcome of the out-of-range store.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        rd1, rd0;
    logic [31:0] ra1, ra0, wa1, wa0, wd1, wd0;
    logic [3:0]  we1, we0;
    logic        busy1, busy0, ack1, ack0, err1, err0;
    logic [31:0] rdata1, rdata0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u_dut1 (
        .clk(clk), .reset(reset),
        .read_address(ra1), .read(rd1), .write_address(wa1), .write_data(wd1),
        .we_mem(we1), .busy(busy1), .ack(ack1), .read_data(rdata1), .error(err1)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_dut0 (
        .clk(clk), .reset(reset),
        .read_address(ra0), .read(rd0), .write_address(wa0), .write_data(wd0),
        .we_mem(we0), .busy(busy0), .ack(ack0), .read_data(rdata0), .error(err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic busy_of(input bit sel);
        return sel ? busy1 : busy0;
    endfunction

    task automatic drive(input bit sel, input logic rd, input logic [31:0] ra,
                         input logic [3:0] we, input logic [31:0] wa, input logic [31:0] wd);
        if (sel) begin
            rd1 = rd; ra1 = ra; we1 = we; wa1 = wa; wd1 = wd;
        end else begin
            rd0 = rd; ra0 = ra; we0 = we; wa0 = wa; wd0 = wd;
        end
    endtask

    // One access: waits for idle, presents the request for one edge, then
    // scrambles the request inputs (with read/we low) and counts cycles to ack.
    // lat = number of sampled cycles after the accepting edge, -1 on timeout.
    task automatic access(input bit sel, input logic rd, input logic [31:0] ra,
                          input logic [3:0] we, input logic [31:0] wa, input logic [31:0] wd,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output logic bsy);
        int n = 0;
        while (busy_of(sel) && n < 20) begin
            @(negedge clk);
            n++;
        end
        drive(sel, rd, ra, we, wa, wd);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 32'hFFFF_FFFC, 4'h0, 32'hFFFF_FFFC, 32'h0BAD_0BAD);
        lat = -1; rdata = 32'hx; err = 1'bx; bsy = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (sel ? ack1 : ack0) begin
                lat   = k;
                rdata = sel ? rdata1 : rdata0;
                err   = sel ? err1 : err0;
                bsy   = busy_of(sel);
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] rdata;
        logic        err, bsy;
        int          acks;
        logic        seen;

        reset = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        // Reset state.
        check("rst_busy",  32'(busy1),  32'd0);
        check("rst_ack",   32'(ack1),   32'd0);
        check("rst_rdata", rdata1,      32'd0);
        check("rst_error", 32'(err1),   32'd0);
        check("rst_busy0", 32'(busy0),  32'd0);

        // Full-word store then load, WAIT_STATES=1.
        access(1'b1, 1'b0, 32'h0, 4'hF, 32'h10, 32'hDEAD_BEEF, lat, rdata, err, bsy);
        check("wr_lat",   32'(lat), 32'd2);
        check("wr_err",   32'(err), 32'd0);
        check("wr_busy",  32'(bsy), 32'd1);
        access(1'b1, 1'b1, 32'h10, 4'h0, 32'h0, 32'h0, lat, rdata, err, bsy);
        check("rd_lat",   32'(lat), 32'd2);
        check("rd_data",  rdata,    32'hDEAD_BEEF);
        check("rd_err",   32'(err), 32'd0);
        @(negedge clk);
        check("rd_busy_drop", 32'(busy1), 32'd0);

        // Write-only request leaves read_data untouched.
        access(1'b1, 1'b0, 32'h0, 4'hF, 32'h10, 32'h0, lat, rdata, err, bsy);
        check("wo_lat",   32'(lat), 32'd2);
        check("wo_rdata", rdata,    32'hDEAD_BEEF);

        // Single byte lane 2 via unaligned address 0x12.
        access(1'b1, 1'b0, 32'h0, 4'b0100, 32'h12, 32'h5A5A_5A5A, lat, rdata, err, bsy);
        access(1'b1, 1'b1, 32'h10, 4'h0, 32'h0, 32'h0, lat, rdata, err, bsy);
        check("lane_data", rdata, 32'h005A_0000);

        // Read-before-write on an aliasing request.
        access(1'b1, 1'b0, 32'h0, 4'hF, 32'h20, 32'h7, lat, rdata, err, bsy);
        access(1'b1, 1'b1, 32'h20, 4'hF, 32'h20, 32'h1, lat, rdata, err, bsy);
        check("rbw_old", rdata, 32'h7);
        access(1'b1, 1'b1, 32'h20, 4'h0, 32'h0, 32'h0, lat, rdata, err, bsy);
        check("rbw_new", rdata, 32'h1);

        // Reset while a store is waiting: store discarded, RAM preserved.
        access(1'b1, 1'b0, 32'h0, 4'hF, 32'h30, 32'h1111_1111, lat, rdata, err, bsy);
        access(1'b1, 1'b1, 32'h30, 4'h0, 32'h0, 32'h0, lat, rdata, err, bsy);
        check("pre_rst_data", rdata, 32'h1111_1111);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 4'hF, 32'h30, 32'h2222_2222);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        check("in_wait_busy", 32'(busy1), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("mid_rst_busy",  32'(busy1), 32'd0);
        check("mid_rst_ack",   32'(ack1),  32'd0);
        check("mid_rst_rdata", rdata1,     32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | ack1;
        end
        check("mid_rst_no_ack", 32'(seen), 32'd0);
        access(1'b1, 1'b1, 32'h30, 4'h0, 32'h0, 32'h0, lat, rdata, err, bsy);
        check("mid_rst_ram", rdata, 32'h1111_1111);

        // Out-of-range store to 0x1000 (one RAM span above word 0).
        access(1'b1, 1'b0, 32'h0, 4'hF, 32'h0, 32'hCAFE_F00D, lat, rdata, err, bsy);
        access(1'b1, 1'b0, 32'h0, 4'hF, 32'h1000, 32'h1234_5678, lat, rdata, err, bsy);
        check("oor_lat", 32'(lat), 32'd2);
`ifdef DMEM_RANGE_CHECK_EN
        check("oor_err", 32'(err), 32'd1);
        access(1'b1, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0, lat, rdata, err, bsy);
        check("oor_word0", rdata, 32'hCAFE_F00D);
        access(1'b1, 1'b1, 32'h1004, 4'h0, 32'h0, 32'h0, lat, rdata, err, bsy);
        check("oor_rd_err",  32'(err), 32'd1);
        check("oor_rd_data", rdata,    32'd0);
        @(negedge clk);
        check("oor_err_clr", 32'(err1), 32'd0);
`else
        check("oor_err", 32'(err), 32'd0);
        access(1'b1, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0, lat, rdata, err, bsy);
        check("alias_word0", rdata, 32'h1234_5678);
`endif

        // WAIT_STATES=0: single store, then reads held high back to back.
        access(1'b0, 1'b0, 32'h0, 4'hF, 32'h40, 32'h0BAD_F00D, lat, rdata, err, bsy);
        check("ws0_lat", 32'(lat), 32'd1);
        @(negedge clk);
        check("ws0_idle", 32'(busy0), 32'd0);
        drive(1'b0, 1'b1, 32'h40, 4'h0, 32'h0, 32'h0);
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("b2b_ack%0d", i),  32'(ack0),  (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("b2b_busy%0d", i), 32'(busy0), (i % 2 == 0) ? 32'd1 : 32'd0);
            if (ack0) begin
                acks++;
                check($sformatf("b2b_data%0d", i), rdata0, 32'h0BAD_F00D);
            end
        end
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        check("b2b_count", 32'(acks), 32'd4);
        @(negedge clk);
        check("b2b_stop", 32'(ack0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
